// File: rtl/max7219_ctrl_seq.sv
// MAX7219 frame sequencer: power-up configuration, then digit refresh
// from an 8x8 display buffer, one max7219_if frame at a time.
module max7219_ctrl_seq #(
    parameter int G_NB_DIGITS = 8,
    parameter int G_TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    input  logic        i_refresh,
    input  logic [3:0]  i_intensity,
    input  logic [7:0]  i_decode_mode,
    input  logic [2:0]  i_scan_limit,
    input  logic        i_digit_wr,
    input  logic [2:0]  i_digit_addr,
    input  logic [7:0]  i_digit_data,
    output logic        o_start,
    output logic        o_en_load,
    output logic [15:0] o_data,
    input  logic        i_done,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_seq_done,
    output logic        o_error
);

    localparam int         TW        = $clog2(G_TIMEOUT + 1);
    localparam logic [2:0] LAST_INIT = 3'd5;
    localparam logic [2:0] LAST_REF  = 3'(G_NB_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    idx_q, idx_n;
    logic          is_init_q, is_init_n;
    logic          pend_init_q, pend_init_n;
    logic          pend_ref_q, pend_ref_n;
    logic          init_done_q, init_done_n;
    logic [TW-1:0] timer_q;
    logic [7:0]    mem_q [8];
    logic [15:0]   data_q;
    logic [15:0]   frame;
    logic [7:0]    digit_rd;
    logic          load_frame;
    logic          ref_ok;
    logic [2:0]    last_idx;

    // A refresh only makes sense once the display is (or will be) configured.
    assign ref_ok = init_done_q | pend_init_q | i_init
                  | ((state_q != IDLE) & is_init_q);

    assign last_idx    = is_init_q ? LAST_INIT : LAST_REF;
    assign o_data      = data_q;
    assign o_init_done = init_done_q;
    assign o_busy      = (state_q != IDLE);

    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        is_init_n   = is_init_q;
        pend_init_n = pend_init_q | i_init;
        pend_ref_n  = pend_ref_q | (i_refresh & ref_ok);
        init_done_n = init_done_q;
        load_frame  = 1'b0;
        o_start     = 1'b0;
        o_en_load   = 1'b0;
        o_seq_done  = 1'b0;
        o_error     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_init_n) begin
                    state_n     = START;
                    idx_n       = '0;
                    is_init_n   = 1'b1;
                    pend_init_n = 1'b0;
                    load_frame  = 1'b1;
                end else if (pend_ref_n) begin
                    state_n    = START;
                    idx_n      = '0;
                    is_init_n  = 1'b0;
                    pend_ref_n = 1'b0;
                    load_frame = 1'b1;
                end
            end
            START: begin
                o_start   = 1'b1;
                o_en_load = 1'b1;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: begin
                o_en_load = 1'b1;
                if (i_done) begin
                    state_n = NEXT;
                end else if (timer_q == TW'(G_TIMEOUT)) begin
                    o_error     = 1'b1;
                    init_done_n = 1'b0;
                    pend_init_n = 1'b0;
                    pend_ref_n  = 1'b0;
                    state_n     = IDLE;
                end
            end
            NEXT: begin
                if (idx_q == last_idx) begin
                    o_seq_done = 1'b1;
                    if (is_init_q) init_done_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n      = idx_q + 3'd1;
                    load_frame = 1'b1;
                    state_n    = START;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Forward a same-cycle write so the frame sees the buffer as of START.
    always_comb begin
        digit_rd = mem_q[idx_n];
        if (i_digit_wr && (i_digit_addr == idx_n)) digit_rd = i_digit_data;
        frame = {8'(idx_n) + 8'd1, digit_rd};
        if (is_init_n) begin
            unique case (idx_n)
                3'd0:    frame = 16'h0C00;
                3'd1:    frame = 16'h0F00;
                3'd2:    frame = {8'h09, i_decode_mode};
                3'd3:    frame = {8'h0A, 4'h0, i_intensity};
                3'd4:    frame = {8'h0B, 5'h00, i_scan_limit};
                3'd5:    frame = 16'h0C01;
                default: frame = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            is_init_q   <= 1'b0;
            pend_init_q <= 1'b0;
            pend_ref_q  <= 1'b0;
            init_done_q <= 1'b0;
            timer_q     <= '0;
            data_q      <= '0;
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            is_init_q   <= is_init_n;
            pend_init_q <= pend_init_n;
            pend_ref_q  <= pend_ref_n;
            init_done_q <= init_done_n;
            if (state_q == START) begin
                timer_q <= TW'(1);
            end else if (state_q == WAIT_DONE) begin
                timer_q <= timer_q + TW'(1);
            end
            if (load_frame) data_q <= frame;
            if (i_digit_wr) mem_q[i_digit_addr] <= i_digit_data;
        end
    end

endmodule

// File: tb/tb_max7219_ctrl_seq.sv
// Bench for max7219_ctrl_seq: table-driven init vectors, directed corner
// sequences and randomized runs against a cycle-logged buffer model.
module tb_max7219_ctrl_seq;

    localparam int NB = 8;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_init = 1'b0;
    logic        i_refresh = 1'b0;
    logic [3:0]  i_intensity = '0;
    logic [7:0]  i_decode_mode = '0;
    logic [2:0]  i_scan_limit = '0;
    logic        i_digit_wr = 1'b0;
    logic [2:0]  i_digit_addr = '0;
    logic [7:0]  i_digit_data = '0;
    logic        i_done = 1'b0;
    logic        o_start, o_en_load, o_busy, o_init_done, o_seq_done, o_error;
    logic [15:0] o_data;

    always #5 clk = ~clk;

    max7219_ctrl_seq #(.G_NB_DIGITS(NB), .G_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_init       (i_init),
        .i_refresh    (i_refresh),
        .i_intensity  (i_intensity),
        .i_decode_mode(i_decode_mode),
        .i_scan_limit (i_scan_limit),
        .i_digit_wr   (i_digit_wr),
        .i_digit_addr (i_digit_addr),
        .i_digit_data (i_digit_data),
        .o_start      (o_start),
        .o_en_load    (o_en_load),
        .o_data       (o_data),
        .i_done       (i_done),
        .o_busy       (o_busy),
        .o_init_done  (o_init_done),
        .o_seq_done   (o_seq_done),
        .o_error      (o_error)
    );

    typedef struct {
        int         c;
        logic [2:0] a;
        logic [7:0] v;
    } wr_t;

    typedef struct {
        logic [7:0]  dm;
        logic [3:0]  in;
        logic [2:0]  sl;
        logic [15:0] e2;
        logic [15:0] e3;
        logic [15:0] e4;
    } init_vec_t;

    wr_t         wlog[$];
    logic [15:0] cap[$];
    int          cap_cyc[$];
    logic [15:0] expq[$];

    int cyc = 0, total = 0, bad = 0;
    int seq_cnt = 0, seq_cyc = 0, err_cnt = 0, err_cyc = 0;
    int pulse_bad = 0, gap_bad = 0, seq_bad = 0, en_bad = 0;
    logic        prev_start = 1'b0, s_en = 1'b0, busy_seen = 1'b0;
    logic [21:0] s_out;
    bit rnd_wr = 0;
    int ref_a = -1, ref_b = -1, wr_at = -1;
    bit ref_a_done, ref_b_done, wr_done;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_out = {o_start, o_en_load, o_data, o_busy, o_init_done, o_seq_done, o_error};
        s_en  = o_en_load;
        if (o_busy) busy_seen = 1'b1;
        if (o_start) begin
            cap.push_back(o_data);
            cap_cyc.push_back(cyc);
            if (prev_start || !o_en_load) pulse_bad++;
        end
        prev_start = o_start;
        if (o_seq_done) begin seq_cnt++; seq_cyc = cyc; end
        if (o_error) begin err_cnt++; err_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        i_init = 1'b0;
        i_refresh = 1'b0;
        i_done = 1'b0;
        i_digit_wr = 1'b0;
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [7:0] v);
        i_digit_wr = 1'b1;
        i_digit_addr = a;
        i_digit_data = v;
        wlog.push_back('{c: cyc, a: a, v: v});
    endtask

    task automatic set_hooks(input int ra, input int rb, input int wa,
                             input logic [2:0] a, input logic [7:0] v);
        ref_a = ra; ref_b = rb; wr_at = wa; wr_addr = a; wr_data = v;
        ref_a_done = 0; ref_b_done = 0; wr_done = 0;
    endtask

    task automatic clear_cap();
        cap.delete(); cap_cyc.delete(); expq.delete();
    endtask

    // Acts as max7219_if: i_done 'lat' cycles after each o_start (never if lat<=0).
    task automatic run(input int lat, input int max_cyc, input int want_seq,
                       input int stop_frames, output bit ok);
        int due, last_done, seq0, err0, n0, sp;
        bit waiting;
        due = -1; last_done = -1; seq0 = seq_cnt; err0 = err_cnt; ok = 0;
        for (int k = 0; k < max_cyc; k++) begin
            if (!ref_a_done && ref_a >= 0 && cap.size() == ref_a) begin
                i_refresh = 1'b1; ref_a_done = 1;
            end
            if (!ref_b_done && ref_b >= 0 && cap.size() == ref_b) begin
                i_refresh = 1'b1; ref_b_done = 1;
            end
            if (!wr_done && wr_at >= 0 && cap.size() == wr_at) begin
                do_wr(wr_addr, wr_data); wr_done = 1;
            end
            if (rnd_wr && $urandom_range(3) == 0)
                do_wr(3'($urandom_range(7)), 8'($urandom_range(255)));
            waiting = (due >= 0);
            if (due >= 0 && cyc == due) begin
                i_done = 1'b1; last_done = cyc; due = -1;
            end
            n0 = cap.size();
            sp = seq_cnt;
            step();
            if (waiting && !s_en) en_bad++;
            if (cap.size() > n0) begin
                if (lat > 0) due = cap_cyc[$] + lat;
                if (last_done >= 0 && cap_cyc[$] - last_done != 2) gap_bad++;
            end
            if (seq_cnt != sp) begin
                if (last_done < 0 || seq_cyc != last_done + 1) seq_bad++;
                last_done = -1;
            end
            if (want_seq > 0 && seq_cnt - seq0 >= want_seq) begin ok = 1; break; end
            if (stop_frames > 0 && cap.size() >= stop_frames) begin ok = 1; break; end
            if (err_cnt != err0) begin
                ok = (want_seq == 0 && stop_frames == 0);
                break;
            end
        end
    endtask

    function automatic logic [7:0] model_digit(input int d, input int s);
        logic [7:0] v;
        v = '0;
        foreach (wlog[i]) if (int'(wlog[i].a) == d && wlog[i].c < s) v = wlog[i].v;
        return v;
    endfunction

    task automatic exp_init(input logic [7:0] dm, input logic [3:0] in, input logic [2:0] sl);
        expq.push_back(16'h0C00);
        expq.push_back(16'h0F00);
        expq.push_back({8'h09, dm});
        expq.push_back({8'h0A, 4'h0, in});
        expq.push_back({8'h0B, 5'h00, sl});
        expq.push_back(16'h0C01);
    endtask

    task automatic exp_ref(input int base);
        int s;
        for (int d = 0; d < NB; d++) begin
            s = (base + d < cap_cyc.size()) ? cap_cyc[base + d] : cyc;
            expq.push_back({8'(d + 1), model_digit(d, s)});
        end
    endtask

    task automatic chk_frames(input string name);
        chk({name, " count"}, cap.size(), expq.size());
        for (int i = 0; i < cap.size() && i < expq.size(); i++)
            chk($sformatf("%s[%0d]", name, i), cap[i], expq[i]);
    endtask

    initial begin
        init_vec_t tbl[3];
        bit ok;
        int s0, e0, n0;
        logic [7:0] dm;
        logic [3:0] in;
        logic [2:0] sl;

        tbl[0] = '{dm: 8'hFF, in: 4'h5, sl: 3'h7, e2: 16'h09FF, e3: 16'h0A05, e4: 16'h0B07};
        tbl[1] = '{dm: 8'h00, in: 4'hF, sl: 3'h0, e2: 16'h0900, e3: 16'h0A0F, e4: 16'h0B00};
        tbl[2] = '{dm: 8'hA5, in: 4'h0, sl: 3'h3, e2: 16'h09A5, e3: 16'h0A00, e4: 16'h0B03};

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset outputs", 32'(s_out), 0);

        // Spurious done and refresh before any init are both ignored.
        busy_seen = 0;
        i_done = 1'b1;
        step();
        i_refresh = 1'b1;
        repeat (10) step();
        chk("idle no start", cap.size(), 0);
        chk("idle no busy", busy_seen, 0);

        set_hooks(-1, -1, -1, 3'd0, 8'd0);
        foreach (tbl[t]) begin
            clear_cap();
            i_decode_mode = tbl[t].dm;
            i_intensity = tbl[t].in;
            i_scan_limit = tbl[t].sl;
            s0 = seq_cnt;
            i_init = 1'b1;
            run(20, 1000, 1, 0, ok);
            chk($sformatf("init%0d done", t), ok, 1);
            chk($sformatf("init%0d count", t), cap.size(), 6);
            if (cap.size() == 6) begin
                chk($sformatf("init%0d f0", t), cap[0], 16'h0C00);
                chk($sformatf("init%0d f1", t), cap[1], 16'h0F00);
                chk($sformatf("init%0d f2", t), cap[2], tbl[t].e2);
                chk($sformatf("init%0d f3", t), cap[3], tbl[t].e3);
                chk($sformatf("init%0d f4", t), cap[4], tbl[t].e4);
                chk($sformatf("init%0d f5", t), cap[5], 16'h0C01);
            end
            chk($sformatf("init%0d seq", t), seq_cnt - s0, 1);
            step();
            chk($sformatf("init%0d init_done", t), s_out[2], 1);
        end

        // Directed refresh from a known buffer.
        for (int i = 0; i < NB; i++) begin
            do_wr(3'(i), 8'(8'h10 + i));
            step();
        end
        clear_cap();
        s0 = seq_cnt;
        i_refresh = 1'b1;
        run(5, 1000, 1, 0, ok);
        chk("refresh done", ok, 1);
        chk("refresh count", cap.size(), NB);
        for (int i = 0; i < cap.size() && i < NB; i++)
            chk($sformatf("refresh f%0d", i), cap[i], 16'(16'h0110 + 16'h0101 * i));
        chk("refresh seq", seq_cnt - s0, 1);

        // A write to digit 7 while frame 0x01 is in flight reaches frame 0x08.
        clear_cap();
        set_hooks(-1, -1, 1, 3'd7, 8'hAA);
        i_refresh = 1'b1;
        run(4, 1000, 1, 0, ok);
        chk("bufwr done", ok, 1);
        exp_ref(0);
        chk_frames("bufwr");
        if (cap.size() == NB) chk("bufwr f7", cap[7], 16'h08AA);

        // After reset: refresh dropped; refresh during init queues once.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wlog.delete();
        step();
        clear_cap();
        busy_seen = 0;
        i_refresh = 1'b1;
        repeat (8) step();
        chk("drop busy", busy_seen, 0);
        chk("drop start", cap.size(), 0);
        set_hooks(2, 3, -1, 3'd0, 8'd0);
        s0 = seq_cnt;
        i_init = 1'b1;
        run(3, 2000, 2, 0, ok);
        chk("init+ref done", ok, 1);
        chk("init+ref seq", seq_cnt - s0, 2);
        repeat (30) step();
        exp_init(i_decode_mode, i_intensity, i_scan_limit);
        exp_ref(6);
        chk_frames("init+ref");

        // Timeout abort with a refresh queued behind it.
        clear_cap();
        set_hooks(1, -1, -1, 3'd0, 8'd0);
        e0 = err_cnt;
        s0 = seq_cnt;
        i_init = 1'b1;
        run(0, 500, 0, 0, ok);
        chk("tmo seen", ok, 1);
        chk("tmo err count", err_cnt - e0, 1);
        if (cap_cyc.size() > 0) chk("tmo latency", err_cyc - cap_cyc[0], TO);
        step();
        chk("tmo busy", s_out[3], 0);
        chk("tmo init_done", s_out[2], 0);
        repeat (10) step();
        chk("tmo pend cleared", cap.size(), 1);
        chk("tmo no seq", seq_cnt - s0, 0);
        clear_cap();
        set_hooks(-1, -1, -1, 3'd0, 8'd0);
        i_init = 1'b1;
        run(2, 500, 1, 0, ok);
        chk("tmo reinit", ok, 1);
        if (cap.size() > 0) chk("tmo reinit f0", cap[0], 16'h0C00);

        // Reset in the third init frame.
        for (int i = 0; i < NB; i++) begin
            do_wr(3'(i), 8'(8'h55 + i));
            step();
        end
        clear_cap();
        i_init = 1'b1;
        run(4, 500, 0, 3, ok);
        chk("rst reach f2", ok, 1);
        s0 = seq_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wlog.delete();
        step();
        chk("rst outputs", 32'(s_out), 0);
        chk("rst no pulses", (seq_cnt - s0) + (err_cnt - e0), 0);
        clear_cap();
        i_init = 1'b1;
        step();
        i_refresh = 1'b1;
        run(3, 2000, 2, 0, ok);
        chk("rst rerun done", ok, 1);
        exp_init(i_decode_mode, i_intensity, i_scan_limit);
        exp_ref(6);
        chk_frames("rst rerun");

        // Randomized runs with writes landing on arbitrary cycles.
        for (int r = 0; r < 4; r++) begin
            dm = 8'($urandom_range(255));
            in = 4'($urandom_range(15));
            sl = 3'($urandom_range(7));
            i_decode_mode = dm;
            i_intensity = in;
            i_scan_limit = sl;
            clear_cap();
            n0 = seq_cnt;
            rnd_wr = 1;
            i_init = 1'b1;
            step();
            i_refresh = 1'b1;
            run($urandom_range(1, 6), 3000, 2, 0, ok);
            rnd_wr = 0;
            chk($sformatf("rnd%0d done", r), ok, 1);
            chk($sformatf("rnd%0d seq", r), seq_cnt - n0, 2);
            exp_init(dm, in, sl);
            exp_ref(6);
            chk_frames($sformatf("rnd%0d", r));
        end

        chk("start pulse width", pulse_bad, 0);
        chk("done-to-start gap", gap_bad, 0);
        chk("done-to-seq_done gap", seq_bad, 0);
        chk("en_load in wait", en_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max7219_ctrl_seq.md
Name: max7219_ctrl_seq

Overview:
Sequencer that drives one max7219_if instance. It issues the MAX7219 power-up configuration frames, then refreshes all digit registers from an internal 8x8 display buffer. It generates the start/en_load/data handshake towards max7219_if, waits for its done pulse before issuing the next frame, and guards each frame with a timeout.

Parameters:
G_NB_DIGITS, 8, number of digit registers refreshed (1..8), digit registers 0x01..G_NB_DIGITS
G_TIMEOUT, 4096, max clk cycles in WAIT_DONE before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
i_init  in  1  one-cycle request: run init sequence
i_refresh  in  1  one-cycle request: run digit refresh sequence
i_intensity  in  4  intensity value, sampled when the frame is built
i_decode_mode  in  8  decode-mode register value
i_scan_limit  in  3  scan-limit register value
i_digit_wr  in  1  buffer write strobe
i_digit_addr  in  3  buffer address (digit 0..7)
i_digit_data  in  8  buffer write data
o_start  out  1  one-cycle start pulse to max7219_if i_start
o_en_load  out  1  to max7219_if i_en_load, 1 while a frame is in progress
o_data  out  16  frame {addr[15:8], data[7:0]} to max7219_if i_data
i_done  in  1  max7219_if o_done pulse
o_busy  out  1  high in any state other than IDLE
o_init_done  out  1  high after a completed init, cleared by error or reset
o_seq_done  out  1  one-cycle pulse after the last frame of a sequence
o_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE. All outputs 0. Buffer cleared to 0x00. Pending flags, index and timer cleared.
- Init sequence, 6 frames in order: 0x0C00, 0x0F00, 0x09&i_decode_mode, 0x0A&"0000"&i_intensity, 0x0B&"00000"&i_scan_limit, 0x0C01.
- Refresh sequence: G_NB_DIGITS frames, 0x01&buf[0] .. G_NB_DIGITS&buf[G_NB_DIGITS-1].
- FSM states: IDLE, START, WAIT_DONE, NEXT.
  - IDLE: a pending init takes priority over a pending refresh. Go to START with index=0.
  - START: o_start=1 for exactly one cycle; o_data built from index. Go to WAIT_DONE.
  - WAIT_DONE: on i_done=1 go to NEXT. If the timer reaches G_TIMEOUT: pulse o_error, clear o_init_done, clear the pending flags, go to IDLE.
  - NEXT: if index is the last, pulse o_seq_done, set o_init_done if this was init, go to IDLE; otherwise increment index and go to START.
- Timing: request sampled in IDLE at cycle N gives o_start=1 at N+1. i_done at cycle M gives the next o_start at M+2, or o_seq_done at M+1.
- o_data: registered and stable from the o_start cycle until the next frame is built. o_en_load is 1 from START through WAIT_DONE, 0 otherwise.
- i_done outside WAIT_DONE: ignored. The timer resets in START.
- Requests arriving while busy set a single pending flag per type; duplicates merge.
- i_refresh while o_init_done=0 and no init is pending or active: dropped.
- i_init during a refresh: pending; runs after the refresh completes.
- Buffer write: takes effect at the next edge and is allowed at any time. A frame uses the buffer content at its START cycle. A write to the same address in the START cycle is not used; the old data is sent.
- Digit words use the low 8 bits as stored; there is no decode conversion.
- Reset mid-sequence: immediate abort as above. No o_seq_done or o_error pulse.

Test Plan:
- Init: decode=0xFF, intensity=0x5, scan=0x7, i_init pulse, model returns i_done 20 cycles after each o_start -> o_data sequence 0x0C00, 0x0F00, 0x09FF, 0x0A05, 0x0B07, 0x0C01; one o_seq_done; o_init_done=1; o_start pulses exactly 1 cycle each.
- Refresh: write buf[0..7]=0x10..0x17, then i_refresh -> frames 0x0110..0x0817 in order; each o_start occurs 2 cycles after the previous i_done; then o_seq_done.
- Refresh before init: i_refresh after reset -> no o_start, o_busy stays 0. Then i_init followed by i_refresh during init -> 6 init frames then 8 refresh frames, with two o_seq_done pulses.
- Timeout: with G_TIMEOUT=64, i_init and i_done never asserted -> o_error pulse 64 cycles after o_start, o_init_done=0, FSM back in IDLE, a new i_init accepted.
- Reset mid-operation: rst_n=0 for 1 cycle during the 3rd init frame -> all outputs 0 at the next edge; a subsequent i_init restarts at 0x0C00; buffer reads 0x00.
- Buffer write during refresh: write buf[7]=0xAA while frame 0x01 is in progress -> frame 0x08AA is sent. Spurious i_done while IDLE -> ignored, no state change.
